// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding and default widths for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational grant from valids, last winner and priority mode
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_last,
  output logic gnt_any,
  output logic gnt_sel
);

  always_comb begin
    gnt_any = valid0 | valid1;
    gnt_sel = 1'b0;
    if (valid0 && valid1) begin
      // on a tie the port that did not win last time goes first
      gnt_sel = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last;
    end else if (valid1) begin
      gnt_sel = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory interface between the load/store unit
// and the loader/debug port, one access at a time with a rdy watchdog
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_done,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_done,
  output logic          req1_err,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [DW-1:0] mem_wd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_out,
  input  logic          mem_rdy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          rr_last_q, rr_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_wen_q, mem_wen_d;
  logic          mem_ren_q, mem_ren_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;

  logic          gnt_any;
  logic          gnt_sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;
  logic          finish;
  logic          timed_out;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .rr_last (rr_last_q),
    .gnt_any (gnt_any),
    .gnt_sel (gnt_sel)
  );

  assign sel_we    = gnt_sel ? req1_we    : req0_we;
  assign sel_addr  = gnt_sel ? req1_addr  : req0_addr;
  assign sel_wd    = gnt_sel ? req1_wdata : req0_wdata;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign finish    = (state_q == ST_WAIT) && (mem_rdy || timed_out);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    mem_wen_d  = 1'b0;
    mem_ren_d  = 1'b0;
    mem_wd_d   = mem_wd_q;
    mem_addr_d = mem_addr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // the done cycle is not a sampling cycle: a valid held through done is a new request next cycle
        if (gnt_any && !done0_q && !done1_q) begin
          gnt_d      = gnt_sel;
          we_d       = sel_we;
          mem_addr_d = sel_addr;
          mem_wd_d   = sel_wd;
          mem_wen_d  = sel_we;
          mem_ren_d  = ~sel_we;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (finish) begin
          if (mem_rdy && !we_q) begin
            if (gnt_q) rdata1_d = mem_out;
            else       rdata0_d = mem_out;
          end
          done0_d   = ~gnt_q;
          done1_d   = gnt_q;
          err0_d    = ~gnt_q & ~mem_rdy;
          err1_d    = gnt_q & ~mem_rdy;
          rr_last_d = gnt_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      mem_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_wd_q   <= '0;
      mem_addr_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      mem_wen_q  <= mem_wen_d;
      mem_ren_q  <= mem_ren_d;
      mem_wd_q   <= mem_wd_d;
      mem_addr_q <= mem_addr_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign mem_wen    = mem_wen_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wd     = mem_wd_q;
  assign mem_addr   = mem_addr_q;
  assign req0_rdata = rdata0_q;
  assign req0_done  = done0_q;
  assign req0_err   = err0_q;
  assign req1_rdata = rdata1_q;
  assign req1_done  = done1_q;
  assign req1_err   = err1_q;

endmodule
